// File: rtl/program_loader.sv
// Boot-time program loader: turns a COUNT/HI/LO[/CSUM] byte stream into program-memory writes.
// Optional checksum stage is enabled with `define LOADER_CHECKSUM_EN.
module program_loader (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        pm_we,
  output logic [7:0]  pm_addr,
  output logic [10:0] pm_wdata,
  output logic        cpu_run,
  output logic        load_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HI    = 3'd1;
  localparam logic [2:0] S_LO    = 3'd2;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd3;
`endif
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERROR = 3'd5;

  logic [2:0] state;
  logic [8:0] remaining;
  logic [7:0] addr;
  logic [2:0] opcode;
  logic       accepting;
  logic       accept;
  logic [2:0] last_word_state;

  always_comb begin
    accepting = 1'b0;
    case (state)
      S_IDLE, S_HI, S_LO: accepting = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:             accepting = 1'b1;
`endif
      default:            accepting = 1'b0;
    endcase
  end

  assign in_ready   = reset_n && accepting;
  assign accept     = in_valid && in_ready;
  assign load_error = (state == S_ERROR);

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic [7:0] csum_next;

  assign csum_next       = csum + in_data;
  assign last_word_state = S_CSUM;
  assign cpu_run         = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      csum <= 8'd0;
    end else if (accept) begin
      csum <= csum_next;
    end
  end
`else
  logic run_q;

  assign last_word_state = S_DONE;
  assign cpu_run         = run_q;

  // Release one edge after DONE is entered so the final write has landed first.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      run_q <= 1'b0;
    end else if (state == S_DONE) begin
      run_q <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      remaining <= 9'd0;
      addr      <= 8'd0;
      opcode    <= 3'd0;
      pm_we     <= 1'b0;
      pm_addr   <= 8'd0;
      pm_wdata  <= 11'd0;
    end else begin
      pm_we <= 1'b0;
      if (accept) begin
        case (state)
          S_IDLE: begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            addr      <= 8'd0;
            state     <= S_HI;
          end
          S_HI: begin
            if (in_data[7:3] == 5'd0) begin
              opcode <= in_data[2:0];
              state  <= S_LO;
            end else begin
              state <= S_ERROR;
            end
          end
          S_LO: begin
            pm_we     <= 1'b1;
            pm_addr   <= addr;
            pm_wdata  <= {opcode, in_data};
            addr      <= addr + 8'd1;
            remaining <= remaining - 9'd1;
            state     <= (remaining == 9'd1) ? last_word_state : S_HI;
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            state <= (csum_next == 8'd0) ? S_DONE : S_ERROR;
          end
`endif
          default: state <= state;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboarded write checks plus per-scenario status checks.
// Follows the DUT build: define LOADER_CHECKSUM_EN for both to exercise the checksum stage.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [10:0] pm_wdata;
  logic        cpu_run;
  logic        load_error;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [18:0] exp_q[$];
  logic [7:0]  stream[$];
  logic [10:0] words[$];
  logic [18:0] mon_exp;
  logic        prev_we = 1'b0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_run    (cpu_run),
    .load_error (load_error)
  );

  // Write scoreboard: every strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (pm_we === 1'b1) begin
      tests_run++;
      if (prev_we !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL we_consecutive actual=%b required=0", prev_we);
      end
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("[TB] FAIL unexpected_write addr=%h data=%h required=none", pm_addr, pm_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({pm_addr, pm_wdata} !== mon_exp)
        begin
          tests_failed++;
          $display("[TB] FAIL write actual=%h/%h required=%h/%h",
                   pm_addr, pm_wdata, mon_exp[18:11], mon_exp[10:0]);
        end
      end
    end
    prev_we = pm_we;
  end

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
  endtask

  task automatic build_stream();
    logic [7:0] sum;
    logic [7:0] b;
    int n;
    n = words.size();
    stream.delete();
    b = 8'(n);
    stream.push_back(b);
    sum = b;
    for (int i = 0; i < n; i++) begin
      b = {5'd0, words[i][10:8]};
      stream.push_back(b);
      sum = sum + b;
      b = words[i][7:0];
      stream.push_back(b);
      sum = sum + b;
      exp_q.push_back({8'(i), words[i]});
    end
`ifdef LOADER_CHECKSUM_EN
    b = 8'd0 - sum;
    stream.push_back(b);
`endif
  endtask

  task automatic applyStimulus(input int max_gap);
    int gap;
    for (int i = 0; i < stream.size(); i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      in_data  = stream[i];
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic settle_release();
`ifndef LOADER_CHECKSUM_EN
    @(posedge clk); #1;
`endif
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_in_ready actual=%b required=0", in_ready); end
    tests_run++; if (pm_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_pm_we actual=%b required=0", pm_we); end
    tests_run++; if (pm_addr !== 8'd0) begin tests_failed++; $display("[TB] FAIL rst_pm_addr actual=%h required=00", pm_addr); end
    tests_run++; if (pm_wdata !== 11'd0) begin tests_failed++; $display("[TB] FAIL rst_pm_wdata actual=%h required=000", pm_wdata); end
    tests_run++; if (cpu_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_cpu_run actual=%b required=0", cpu_run); end
    tests_run++; if (load_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_load_error actual=%b required=0", load_error); end
    reset_n = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_in_ready actual=%b required=1", in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL idle_hold actual=%b required=1", in_ready); end
  endtask

  task automatic test_basic();
    do_reset();
    words = '{11'h201, 11'h003};
    build_stream();
    applyStimulus(0);
`ifndef LOADER_CHECKSUM_EN
    tests_run++; if (cpu_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_run_early actual=%b required=0", cpu_run); end
`endif
    settle_release();
    tests_run++; if (cpu_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_cpu_run actual=%b required=1", cpu_run); end
    tests_run++; if (load_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_load_error actual=%b required=0", load_error); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_in_ready actual=%b required=0", in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL basic_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_bad_csum();
    do_reset();
    words = '{11'h201, 11'h003};
    build_stream();
    stream[stream.size() - 1] = 8'hF9;
    applyStimulus(0);
    tests_run++; if (load_error !== 1'b1) begin tests_failed++; $display("[TB] FAIL csum_load_error actual=%b required=1", load_error); end
    tests_run++; if (cpu_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL csum_cpu_run actual=%b required=0", cpu_run); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL csum_in_ready actual=%b required=0", in_ready); end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL csum_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask
`endif

  task automatic test_bad_hi();
    do_reset();
    stream = '{8'h01, 8'h08};
    applyStimulus(0);
    tests_run++; if (load_error !== 1'b1) begin tests_failed++; $display("[TB] FAIL badhi_load_error actual=%b required=1", load_error); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL badhi_in_ready actual=%b required=0", in_ready); end
    tests_run++; if (pm_we !== 1'b0) begin tests_failed++; $display("[TB] FAIL badhi_pm_we actual=%b required=0", pm_we); end
    in_data  = 8'h55;
    in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    tests_run++; if (cpu_run !== 1'b0) begin tests_failed++; $display("[TB] FAIL badhi_cpu_run actual=%b required=0", cpu_run); end
    tests_run++; if (load_error !== 1'b1) begin tests_failed++; $display("[TB] FAIL badhi_sticky actual=%b required=1", load_error); end
    exp_q.delete();
  endtask

  task automatic test_full_256();
    do_reset();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back({3'd0, 8'(i)});
    build_stream();
    applyStimulus(0);
    settle_release();
    tests_run++; if (cpu_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_cpu_run actual=%b required=1", cpu_run); end
    tests_run++; if (load_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL full_load_error actual=%b required=0", load_error); end
    in_data  = 8'h00;
    in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL full_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_gaps();
    do_reset();
    words = '{11'h1FF, 11'h600, 11'h0A5};
    build_stream();
    applyStimulus(4);
    settle_release();
    tests_run++; if (cpu_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL gaps_cpu_run actual=%b required=1", cpu_run); end
    tests_run++; if (load_error !== 1'b0) begin tests_failed++; $display("[TB] FAIL gaps_load_error actual=%b required=0", load_error); end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL gaps_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    do_reset();
    words = '{11'h111, 11'h222, 11'h333, 11'h444};
    build_stream();
    stream = stream[0:4];
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    applyStimulus(0);
    do_reset();
    tests_run++; if (pm_addr !== 8'd0) begin tests_failed++; $display("[TB] FAIL mid_pm_addr actual=%h required=00", pm_addr); end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL mid_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
    words = '{11'h7A5};
    build_stream();
    applyStimulus(1);
    settle_release();
    tests_run++; if (cpu_run !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_cpu_run actual=%b required=1", cpu_run); end
    repeat (3) begin @(posedge clk); #1; end
    tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("[TB] FAIL mid_new_writes_left actual=%0d required=0", exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'd0;
    test_reset();
    test_basic();
`ifdef LOADER_CHECKSUM_EN
    test_bad_csum();
`endif
    test_bad_hi();
    test_full_256();
    test_gaps();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Upstream boot stage for the accumulator core. Accepts a byte stream over a valid/ready handshake, assembles 11-bit instruction words and writes them through the core's program-memory write port starting at address 0. Holds the core stopped (`cpu_run`=0) until a complete, well-formed image has been written, then releases it. Replaces the static hex-file image when a host downloads programs at run time.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` valid this cycle.
- `in_ready` out 1: loader accepts a byte this cycle; transfer occurs when `in_valid`&`in_ready` at the rising edge.
- `pm_we` out 1: program-memory write strobe, one-cycle pulse per word.
- `pm_addr` out 8: write address.
- `pm_wdata` out 11: instruction word, {opcode[2:0], operand[7:0]}.
- `cpu_run` out 1: core released; level, sticky until reset.
- `load_error` out 1: malformed image; level, sticky until reset.

## Operation
- Stream format: COUNT, then COUNT word pairs (HI, LO), then CSUM (CSUM only with `LOADER_CHECKSUM_EN`).
- COUNT: number of words, 1–255; value 0 means 256.
- HI: bits [2:0] are opcode (word bits 10:8); bits [7:3] must be 0. LO: word bits 7:0.
- States: IDLE (awaiting COUNT), HI, LO, CSUM, DONE, ERROR.
- IDLE --COUNT--> HI; remaining := COUNT (9-bit, 0 maps to 256); addr := 0.
- HI --byte, [7:3]==0--> LO (opcode latched); HI --byte, [7:3]!=0--> ERROR.
- LO --byte--> write word at addr; addr increments (8-bit, wraps 255→0 only after the 256th word, never reused); remaining decrements; if remaining becomes 0 → CSUM (or DONE), else → HI.
- CSUM --byte--> DONE if 8-bit sum of all accepted bytes (COUNT, every HI/LO, CSUM) == 0 mod 256, else ERROR.
- DONE: `cpu_run`=1, `in_ready`=0; bytes are not accepted. ERROR: `load_error`=1, `cpu_run`=0, `in_ready`=0. Both exit only by reset.
- `in_ready`=1 in IDLE, HI, LO, CSUM; no backpressure within those states.
- Running checksum: 8-bit, wraps, cleared on reset.

## Timing
- Reset (`reset_n`=0 at a rising edge): state IDLE; `in_ready` reads 0 while `reset_n` is low, otherwise IDLE applies; `pm_we`=0, `pm_addr`=0, `pm_wdata`=0, `cpu_run`=0, `load_error`=0, checksum=0. A reset mid-load abandons the load; words already written stay in memory and are overwritten by the next load.
- `in_valid` low in any accepting state: state holds, no side effects; gaps of any length are legal.
- Write latency: the LO byte accepted at edge k drives `pm_we`=1, `pm_addr`, `pm_wdata` registered during cycle k..k+1 only; `pm_we` is 0 in the following cycle unless another LO is accepted.
- Back-to-back: minimum 2 cycles per word (HI, LO), so `pm_we` is never high in consecutive cycles.
- `cpu_run` rises at the edge accepting a valid CSUM. Without the checksum option, it rises at the edge after the final `pm_we` cycle, so the last write has completed before the core fetches.
- `load_error` rises at the edge accepting the offending byte; no `pm_we` is issued for a rejected HI.

## Configuration
- `LOADER_CHECKSUM_EN` defined: CSUM state is present; the image is released only if the checksum matches, otherwise ERROR.
- Not defined: CSUM state and checksum accumulator are removed; after the final LO the loader goes to DONE. ERROR is reachable only through a bad HI byte.

## Test plan
- COUNT=2, words 0x201, 0x003, CSUM=0x100−(0x02+0x02+0x01+0x00+0x03)=0xF8, `in_valid` held high → `pm_we` pulses at addr 0 with data 0x201 and at addr 1 with data 0x003; `cpu_run`=1 one edge after CSUM; `load_error`=0.
- Same stream with CSUM=0xF9 → both writes occur; `load_error`=1, `cpu_run`=0, `in_ready`=0.
- COUNT=1, HI=0x08 → ERROR at that edge; no `pm_we`; the following LO byte is not accepted.
- COUNT=0 with 256 words (data = addr) plus a valid CSUM → 256 writes at addr 0..255; `cpu_run`=1; `pm_addr` does not wrap onto a 257th write.
- Random `in_valid` gaps inside a 3-word image → writes and the final checksum result are identical to the gap-free run.
- `reset_n` low after the 2nd word of a 4-word load, then a fresh 1-word image → state back to IDLE; new word written at addr 0; `cpu_run`=1.
